dequantizer: RTL and testbench

//  Inverse of the wake-word datapath quantizer. Widens a stream of signed
//  I_BW-bit activations to O_BW-bit accumulator values: sign-extend, then

---
 rtl/dequantizer_if.sv | 37 +++
 rtl/dequantizer.sv | 138 +++++++++++++
 tb/tb_dequantizer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dequantizer_if.sv
// dequantizer_if: stream bundle between a sample producer/consumer and the
// dequantizer. One interface carries both the input beat channel and the
// widened output beat channel so a single instance wires the whole block.
//   shift_i/data_i/valid_i/last_i : input beat (producer -> dequantizer)
//   ready_o                       : dequantizer can take an input beat
//   data_o/valid_o/last_o/sat_o   : output beat (dequantizer -> consumer)
//   ready_i                       : consumer takes the output beat
//   sat_cnt_o                     : clamped-beat count of current/last frame
// Modports: slave = the dequantizer, master = the environment driving it.
interface dequantizer_if #(
    parameter int I_BW     = 8,
    parameter int O_BW     = 32,
    parameter int SHIFT_BW = $clog2(O_BW),
    parameter int CNT_BW   = 16
);
    logic [SHIFT_BW-1:0] shift_i;
    logic [I_BW-1:0]     data_i;
    logic                valid_i;
    logic                last_i;
    logic                ready_o;
    logic [O_BW-1:0]     data_o;
    logic                valid_o;
    logic                last_o;
    logic                ready_i;
    logic                sat_o;
    logic [CNT_BW-1:0]   sat_cnt_o;

    modport slave (
        input  shift_i, data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, last_o, sat_o, sat_cnt_o
    );

    modport master (
        output shift_i, data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, sat_o, sat_cnt_o
    );
endinterface

// File: rtl/dequantizer.sv
// dequantizer: widens signed I_BW-bit activations to O_BW-bit accumulator
// values. Each beat is sign-extended, arithmetically shifted left by a
// per-frame amount, then saturated to O_BW. Two-stage valid/ready pipeline
// (S1 = shift, S2 = saturate/output regs) with full backpressure.
// Ports:
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset; drops beats in flight
//   bus      : dequantizer_if.slave (input beat channel, output beat channel,
//              per-frame saturation count sat_cnt_o)
module dequantizer #(
    parameter int I_BW     = 8,
    parameter int O_BW     = 32,
    parameter int SHIFT_BW = $clog2(O_BW),
    parameter int CNT_BW   = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    dequantizer_if.slave   bus
);
    // Wide enough that the largest shift of any input never overflows.
    localparam int WIDE_BW = I_BW + (1 << SHIFT_BW) - 1;

    localparam logic signed [WIDE_BW-1:0] WIDE_MAX = {{(WIDE_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [WIDE_BW-1:0] WIDE_MIN = {{(WIDE_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};
    localparam logic [O_BW-1:0] OUT_MAX = {1'b0, {(O_BW-1){1'b1}}};
    localparam logic [O_BW-1:0] OUT_MIN = {1'b1, {(O_BW-1){1'b0}}};

    logic                      frame_start;
    logic [SHIFT_BW-1:0]       shift_q;
    logic [SHIFT_BW-1:0]       shift_eff;
    logic signed [WIDE_BW-1:0] wide_in;

    logic                      s1_valid;
    logic                      s1_last;
    logic signed [WIDE_BW-1:0] s1_wide;

    logic                      s2_valid;
    logic [O_BW-1:0]           s2_data;
    logic                      s2_last;
    logic                      s2_sat;

    logic                      s1_adv;
    logic                      s2_adv;
    logic                      in_ready;
    logic                      in_xfer;
    logic                      out_xfer;

    logic [O_BW-1:0]           sat_data;
    logic                      sat_flag;

    logic [CNT_BW-1:0]         sat_cnt;
    logic                      cnt_restart;

    assign s2_adv   = !s2_valid || bus.ready_i;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s1_adv;
    assign in_xfer  = bus.valid_i && in_ready;
    assign out_xfer = s2_valid && bus.ready_i;

    // The first beat of a frame uses the live shift_i (it is latched on that
    // same transfer); later beats use the latched copy.
    assign shift_eff = frame_start ? bus.shift_i : shift_q;
    assign wide_in   = {{(WIDE_BW-I_BW){bus.data_i[I_BW-1]}}, bus.data_i} <<< shift_eff;

    always_comb begin
        sat_data = s1_wide[O_BW-1:0];
        sat_flag = 1'b0;
        if (s1_wide > WIDE_MAX) begin
            sat_data = OUT_MAX;
            sat_flag = 1'b1;
        end else if (s1_wide < WIDE_MIN) begin
            sat_data = OUT_MIN;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_start <= 1'b1;
            shift_q     <= '0;
        end else if (in_xfer) begin
            if (frame_start) shift_q <= bus.shift_i;
            frame_start <= bus.last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_wide  <= '0;
        end else if (in_ready) begin
            s1_valid <= bus.valid_i;
            if (in_xfer) begin
                s1_wide <= wide_in;
                s1_last <= bus.last_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_data;
                s2_last <= s1_last;
                s2_sat  <= sat_flag;
            end
        end
    end

    // cnt_restart marks that the next output transfer opens a new frame, so
    // the count holds the previous frame's total until then.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sat_cnt     <= '0;
            cnt_restart <= 1'b1;
        end else if (out_xfer) begin
            cnt_restart <= s2_last;
            if (cnt_restart)
                sat_cnt <= {{(CNT_BW-1){1'b0}}, s2_sat};
            else if (s2_sat && (sat_cnt != {CNT_BW{1'b1}}))
                sat_cnt <= sat_cnt + CNT_BW'(1);
        end
    end

    assign bus.ready_o   = in_ready;
    assign bus.valid_o   = s2_valid;
    assign bus.data_o    = s2_data;
    assign bus.last_o    = s2_last;
    assign bus.sat_o     = s2_sat;
    assign bus.sat_cnt_o = sat_cnt;
endmodule

// File: tb/tb_dequantizer.sv
// tb_dequantizer: scoreboard bench for the dequantizer. Drivers push the
// expected output beat when an input beat transfers; a negedge monitor pops
// and compares on every output transfer, tracks the expected saturation
// count, and checks output stability while stalled.
module tb_dequantizer;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    dequantizer_if bus ();
    dequantizer_if #(.CNT_BW(2)) bus2 ();

    dequantizer u_dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));
    dequantizer #(.CNT_BW(2)) u_dut2 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus2));

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        s;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   stall_mode = 0;  // 0: ready_i=1, 1: random, 2: held low

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready, changed just after the active edge.
    always @(posedge clk_i) begin
        #1;
        case (stall_mode)
            0:       bus.ready_i = 1'b1;
            1:       bus.ready_i = 1'($urandom_range(0, 1));
            default: bus.ready_i = 1'b0;
        endcase
    end

    // Monitor: scoreboard pop, stall stability, sat count tracking.
    logic [31:0] hold_d;
    logic        hold_l, hold_s, held;
    logic        cnt_pend, cnt_first, prev_last;
    logic [15:0] exp_cnt;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            held = 1'b0; cnt_pend = 1'b0; cnt_first = 1'b1; prev_last = 1'b0; exp_cnt = '0;
        end else begin
            if (cnt_pend) begin
                chk("sat_cnt", 64'(bus.sat_cnt_o), 64'(exp_cnt));
                cnt_pend = 1'b0;
            end
            if (held) begin
                chk("stall_valid", 64'(bus.valid_o), 64'd1);
                chk("stall_data", 64'(bus.data_o), 64'(hold_d));
                chk("stall_last_sat", {62'd0, bus.last_o, bus.sat_o}, {62'd0, hold_l, hold_s});
            end
            if (!bus.ready_o)
                chk("ready_low_when_full", 64'(bus.valid_o && !bus.ready_i), 64'd1);
            held = 1'b0;
            if (bus.valid_o && bus.ready_i) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_output: got %0h expected none", bus.data_o);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("data_o", 64'(bus.data_o), 64'(e.d));
                    chk("last_o", 64'(bus.last_o), 64'(e.l));
                    chk("sat_o", 64'(bus.sat_o), 64'(e.s));
                    if (cnt_first || prev_last) exp_cnt = 16'(e.s);
                    else if (e.s && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    cnt_first = 1'b0;
                    prev_last = e.l;
                    cnt_pend = 1'b1;
                end
            end else if (bus.valid_o) begin
                held = 1'b1; hold_d = bus.data_o; hold_l = bus.last_o; hold_s = bus.sat_o;
            end
        end
    end

    // Call at a negedge; returns at the negedge after the input transfer.
    task automatic send(input logic [7:0] d, input logic l, input logic [4:0] sh,
                        input logic [31:0] ed, input logic es);
        exp_t e;
        int   n;
        bus.data_i = d; bus.last_i = l; bus.shift_i = sh; bus.valid_i = 1'b1;
        n = 0;
        forever begin
            #1;
            if (bus.ready_o) break;
            n++;
            if (n > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: got ready_o=0 expected ready_o=1");
                bus.valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        e.d = ed; e.l = l; e.s = es;
        sbq.push_back(e);
        @(negedge clk_i);
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0) && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic void model(input logic [7:0] d, input int sh,
                                  output logic [31:0] ed, output logic es);
        longint v;
        v = longint'($signed(d)) * (longint'(1) << sh);
        es = 1'b1;
        if (v > 64'sd2147483647) ed = 32'h7FFFFFFF;
        else if (v < -64'sd2147483648) ed = 32'h80000000;
        else begin ed = v[31:0]; es = 1'b0; end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed;
        logic        es;
        bus.valid_i = 0; bus.last_i = 0; bus.data_i = 0; bus.shift_i = 0; bus.ready_i = 1;
        bus2.valid_i = 0; bus2.last_i = 0; bus2.data_i = 0; bus2.shift_i = 0; bus2.ready_i = 1;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("rst_ready_o", 64'(bus.ready_o), 64'd1);
        @(negedge clk_i);
        chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst_data_o", 64'(bus.data_o), 64'd0);
        chk("rst_sat_cnt", 64'(bus.sat_cnt_o), 64'd0);

        // 1: basic shift, latency 2
        send(8'h05, 1'b0, 5'd4, 32'h00000050, 1'b0);
        chk("lat_valid_early", 64'(bus.valid_o), 64'd0);
        send(8'hFB, 1'b1, 5'd4, 32'hFFFFFFB0, 1'b0);
        chk("lat_valid_2cyc", 64'(bus.valid_o), 64'd1);
        chk("lat_data_2cyc", 64'(bus.data_o), 64'h50);
        drain();
        chk("t1_sat_cnt", 64'(bus.sat_cnt_o), 64'd0);

        // 2: shift 31 saturation both ways
        send(8'h01, 1'b0, 5'd31, 32'h7FFFFFFF, 1'b1);
        send(8'hFF, 1'b0, 5'd31, 32'h80000000, 1'b0);
        send(8'h80, 1'b1, 5'd31, 32'h80000000, 1'b1);
        drain();
        chk("t2_sat_cnt", 64'(bus.sat_cnt_o), 64'd2);

        // 3: mid-frame shift change ignored; next frame resamples
        send(8'h7F, 1'b0, 5'd24, 32'h7F000000, 1'b0);
        send(8'h7F, 1'b0, 5'd0,  32'h7F000000, 1'b0);
        send(8'h7F, 1'b1, 5'd0,  32'h7F000000, 1'b0);
        drain();
        chk("t3a_sat_cnt", 64'(bus.sat_cnt_o), 64'd0);
        send(8'h7F, 1'b1, 5'd25, 32'h7FFFFFFF, 1'b1);
        drain();
        chk("t3b_sat_cnt", 64'(bus.sat_cnt_o), 64'd1);

        // 4: random stream under random backpressure
        stall_mode = 1;
        begin
            int beats, flen, fshift;
            beats = 0;
            while (beats < 1000) begin
                flen = $urandom_range(1, 8);
                fshift = $urandom_range(0, 31);
                for (int k = 0; k < flen; k++) begin
                    logic [7:0] d;
                    logic [4:0] sh_in;
                    d = 8'($urandom);
                    sh_in = (k == 0) ? 5'(fshift) : 5'($urandom);
                    model(d, fshift, ed, es);
                    send(d, k == flen - 1, sh_in, ed, es);
                    beats++;
                end
            end
        end
        drain();
        stall_mode = 0;
        @(negedge clk_i);

        // 5: reset mid-frame with both stages full
        stall_mode = 2;
        @(negedge clk_i);
        @(negedge clk_i);
        send(8'h11, 1'b0, 5'd3, 32'h88, 1'b0);
        send(8'h22, 1'b0, 5'd3, 32'h110, 1'b0);
        chk("t5_full_ready_o", 64'(bus.ready_o), 64'd0);
        #2;
        rst_n_i = 1'b0;
        sbq.delete();
        #1;
        chk("t5_rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("t5_rst_sat_cnt", 64'(bus.sat_cnt_o), 64'd0);
        stall_mode = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("t5_ready_after_rst", 64'(bus.ready_o), 64'd1);
        @(negedge clk_i);
        send(8'h01, 1'b1, 5'd8, 32'h00000100, 1'b0);
        drain();
        chk("t5_sat_cnt", 64'(bus.sat_cnt_o), 64'd0);

        // 6: narrow counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            bus2.data_i = 8'h7F; bus2.shift_i = 5'd31; bus2.last_i = (k == 4); bus2.valid_i = 1'b1;
            #1;
            chk("t6_ready_o", 64'(bus2.ready_o), 64'd1);
            @(negedge clk_i);
        end
        bus2.valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("t6_sat_cnt_sticks", 64'(bus2.sat_cnt_o), 64'd3);
        chk("t6_data_o", 64'(bus2.data_o), 64'h7FFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
